mem_port_arbiter: RTL and testbench

- Shares the single memory port of the pipelined MIPS core between instruction fetch (I-side) and load/store (D-side).
- Arbitrates between the two sides and sequences one outstanding transaction at a time.
- Generates big-endian byte enables and write-lane replication from the decoded MemSize.
- Extracts and extends load data, and rejects misaligned accesses before they reach memory.

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store,
// with one outstanding transaction, big-endian lane steering and load extension.
module mem_port_arbiter #(
  parameter int AddrWidth = 32
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   IReq,
  input  logic [AddrWidth-1:0]   IAddr,
  output logic                   IReady,
  output logic                   IValid,
  output logic [31:0]            IData,
  input  logic                   DReq,
  input  logic                   DWrite,
  input  logic [AddrWidth-1:0]   DAddr,
  input  logic [31:0]            DWData,
  input  logic [1:0]             DSize,
  input  logic                   DUnsigned,
  output logic                   DReady,
  output logic                   DValid,
  output logic [31:0]            DRData,
  output logic                   DMisaligned,
  output logic                   MemReq,
  output logic [AddrWidth-3:0]   MemAddr,
  output logic [3:0]             MemWE,
  output logic [31:0]            MemWData,
  input  logic [31:0]            MemRData,
  input  logic                   MemRValid,
  output logic                   Busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  logic [1:0] state;
  logic       last_d;
  logic [1:0] size_q;
  logic [1:0] lane_q;
  logic       uns_q;
  logic       write_q;

  logic idle;
  logic d_mis;
  logic grant_i;
  logic grant_d;
  logic issue_d;
  logic unused;

  function automatic logic [3:0] wr_enable(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   wr_enable = 4'b1000 >> lane;
      2'b01:   wr_enable = lane[1] ? 4'b0011 : 4'b1100;
      2'b10:   wr_enable = 4'b1111;
      default: wr_enable = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] wr_data(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   wr_data = {4{data[7:0]}};
      2'b01:   wr_data = {2{data[15:0]}};
      default: wr_data = data;
    endcase
  endfunction

  // Big-endian: lane 0 is bits 31:24; narrow loads are right-aligned then extended.
  function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = lane[1] ? word[15:0] : word[31:16];
    case (size)
      2'b00:   extract_load = {{24{~uns & b[7]}}, b};
      2'b01:   extract_load = {{16{~uns & h[15]}}, h};
      default: extract_load = word;
    endcase
  endfunction

  assign unused = ^IAddr[1:0];

  // Grants are gated by reset so every output reads 0 while it is held.
  assign idle    = (state == IDLE) && Reset;
  assign d_mis   = (DSize == 2'b11) || ((DSize == 2'b01) && DAddr[0]) ||
                   ((DSize == 2'b10) && (DAddr[1:0] != 2'b00));
  assign grant_i = idle && IReq && (!DReq || last_d);
  assign grant_d = idle && DReq && (!IReq || !last_d);
  assign issue_d = grant_d && !d_mis;

  assign IReady      = grant_i;
  assign DReady      = grant_d;
  assign DMisaligned = grant_d && d_mis;
  assign MemReq      = grant_i || issue_d;
  assign Busy        = (state != IDLE);

  always_comb begin
    MemAddr  = '0;
    MemWE    = 4'b0000;
    MemWData = 32'd0;
    if (grant_i) begin
      MemAddr = IAddr[AddrWidth-1:2];
    end else if (issue_d) begin
      MemAddr = DAddr[AddrWidth-1:2];
      if (DWrite) begin
        MemWE    = wr_enable(DSize, DAddr[1:0]);
        MemWData = wr_data(DSize, DWData);
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      last_d  <= 1'b1;
      size_q  <= 2'b00;
      lane_q  <= 2'b00;
      uns_q   <= 1'b0;
      write_q <= 1'b0;
      IValid  <= 1'b0;
      DValid  <= 1'b0;
      IData   <= 32'd0;
      DRData  <= 32'd0;
    end else begin
      IValid <= 1'b0;
      DValid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_i) begin
            state  <= BUSY_I;
            last_d <= 1'b0;
          end else if (grant_d) begin
            last_d <= 1'b1;
            if (!d_mis) begin
              state   <= BUSY_D;
              size_q  <= DSize;
              lane_q  <= DAddr[1:0];
              uns_q   <= DUnsigned;
              write_q <= DWrite;
            end
          end
        end
        BUSY_I: begin
          if (MemRValid) begin
            state  <= IDLE;
            IValid <= 1'b1;
            IData  <= MemRData;
          end
        end
        BUSY_D: begin
          if (MemRValid) begin
            state  <= IDLE;
            DValid <= 1'b1;
            if (!write_q) DRData <= extract_load(MemRData, size_q, lane_q, uns_q);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected responses into a
// queue, a monitor pops and compares whenever IValid/DValid pulses.
module tb_mem_port_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        IReq;
  logic [31:0] IAddr;
  logic        IReady, IValid;
  logic [31:0] IData;
  logic        DReq, DWrite;
  logic [31:0] DAddr, DWData;
  logic [1:0]  DSize;
  logic        DUnsigned;
  logic        DReady, DValid;
  logic [31:0] DRData;
  logic        DMisaligned;
  logic        MemReq;
  logic [29:0] MemAddr;
  logic [3:0]  MemWE;
  logic [31:0] MemWData;
  logic [31:0] MemRData;
  logic        MemRValid;
  logic        Busy;

  logic resp_v  = 1'b0;
  logic stale_v = 1'b0;
  bit   resp_en = 1'b1;
  assign MemRValid = resp_v | stale_v;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  mem_port_arbiter #(.AddrWidth(32)) dut (
    .Clock(Clock), .Reset(Reset),
    .IReq(IReq), .IAddr(IAddr), .IReady(IReady), .IValid(IValid), .IData(IData),
    .DReq(DReq), .DWrite(DWrite), .DAddr(DAddr), .DWData(DWData), .DSize(DSize),
    .DUnsigned(DUnsigned), .DReady(DReady), .DValid(DValid), .DRData(DRData),
    .DMisaligned(DMisaligned), .MemReq(MemReq), .MemAddr(MemAddr), .MemWE(MemWE),
    .MemWData(MemWData), .MemRData(MemRData), .MemRValid(MemRValid), .Busy(Busy)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_pop(input bit is_d, input logic [31:0] d);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_valid: got %s valid with data %h, expected none", is_d ? "D" : "I", d);
    end else begin
      e = exp_q.pop_front();
      check("valid_side", 32'(is_d), 32'(e.is_d));
      check(is_d ? "drdata" : "idata", d, e.data);
    end
  endtask

  // Memory model: one response, one cycle after each issued request.
  initial forever begin
    @(negedge Clock);
    if (MemReq === 1'b1 && resp_en) begin
      @(posedge Clock); #1 resp_v = 1'b1;
      @(posedge Clock); #1 resp_v = 1'b0;
    end
  end

  initial forever begin
    @(negedge Clock);
    if (Reset === 1'b1) begin
      if (IValid === 1'b1) check_pop(1'b0, IData);
      if (DValid === 1'b1) check_pop(1'b1, DRData);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(negedge Clock);
      k++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic i_txn(input logic [31:0] addr, input logic [31:0] rdata);
    IReq = 1'b1; IAddr = addr; MemRData = rdata;
    @(negedge Clock);
    check("i_ready", 32'(IReady), 32'd1);
    check("i_memreq", 32'(MemReq), 32'd1);
    check("i_memaddr", 32'(MemAddr), addr >> 2);
    check("i_memwe", 32'(MemWE), 32'd0);
    exp_q.push_back('{1'b0, rdata});
    @(posedge Clock); #1 IReq = 1'b0;
    drain();
    @(posedge Clock); #1;
  endtask

  task automatic d_txn(input string nm, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] sz, input bit uns,
                       input logic [31:0] rdata, input logic [3:0] we,
                       input logic [31:0] wd, input logic [31:0] rd);
    DReq = 1'b1; DWrite = wr; DAddr = addr; DWData = wdata; DSize = sz;
    DUnsigned = uns; MemRData = rdata;
    @(negedge Clock);
    check({nm, "_ready"}, 32'(DReady), 32'd1);
    check({nm, "_misaligned"}, 32'(DMisaligned), 32'd0);
    check({nm, "_memreq"}, 32'(MemReq), 32'd1);
    check({nm, "_memaddr"}, 32'(MemAddr), addr >> 2);
    check({nm, "_memwe"}, 32'(MemWE), 32'(we));
    if (wr) check({nm, "_memwdata"}, MemWData, wd);
    exp_q.push_back('{1'b1, rd});
    @(posedge Clock); #1 DReq = 1'b0;
    drain();
    @(posedge Clock); #1;
  endtask

  initial begin
    bit ord [4];
    int ng;
    Reset = 1'b0; IReq = 1'b0; IAddr = '0; DReq = 1'b0; DWrite = 1'b0;
    DAddr = '0; DWData = '0; DSize = 2'b00; DUnsigned = 1'b0; MemRData = '0;

    // reset state
    @(negedge Clock);
    check("rst_iready", 32'(IReady), 32'd0);
    check("rst_ivalid", 32'(IValid), 32'd0);
    check("rst_idata", IData, 32'd0);
    check("rst_dready", 32'(DReady), 32'd0);
    check("rst_dvalid", 32'(DValid), 32'd0);
    check("rst_drdata", DRData, 32'd0);
    check("rst_dmis", 32'(DMisaligned), 32'd0);
    check("rst_memreq", 32'(MemReq), 32'd0);
    check("rst_memaddr", 32'(MemAddr), 32'd0);
    check("rst_memwe", 32'(MemWE), 32'd0);
    check("rst_memwdata", MemWData, 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    @(posedge Clock); #1 Reset = 1'b1;

    // single fetch with minimum latency
    IReq = 1'b1; IAddr = 32'h00400004; MemRData = 32'h8C820000;
    @(negedge Clock);
    check("t1_iready", 32'(IReady), 32'd1);
    check("t1_memreq", 32'(MemReq), 32'd1);
    check("t1_memaddr", 32'(MemAddr), 32'h00100001);
    check("t1_memwe", 32'(MemWE), 32'd0);
    check("t1_busy_t", 32'(Busy), 32'd0);
    exp_q.push_back('{1'b0, 32'h8C820000});
    @(posedge Clock); #1 IReq = 1'b0;
    @(negedge Clock);
    check("t1_busy_t1", 32'(Busy), 32'd1);
    check("t1_memreq_t1", 32'(MemReq), 32'd0);
    check("t1_ivalid_t1", 32'(IValid), 32'd0);
    @(negedge Clock);
    check("t1_ivalid_t2", 32'(IValid), 32'd1);
    check("t1_busy_t2", 32'(Busy), 32'd0);
    drain();
    @(posedge Clock); #1;

    // round-robin with both sides requesting from reset
    Reset = 1'b0;
    IReq = 1'b1; IAddr = 32'h00400000; DReq = 1'b1; DWrite = 1'b0;
    DAddr = 32'h10; DSize = 2'b10; DUnsigned = 1'b0; MemRData = 32'h11223344;
    @(negedge Clock);
    check("rr_rst_iready", 32'(IReady), 32'd0);
    check("rr_rst_dready", 32'(DReady), 32'd0);
    @(posedge Clock); #1 Reset = 1'b1;
    ng = 0;
    for (int c = 0; c < 30 && ng < 4; c++) begin
      @(negedge Clock);
      if (IReady || DReady) begin
        check("rr_one_ready", 32'(IReady && DReady), 32'd0);
        ord[ng] = DReady;
        exp_q.push_back('{DReady, 32'h11223344});
        ng++;
      end
    end
    @(posedge Clock); #1 IReq = 1'b0; DReq = 1'b0;
    check("rr_grant_count", 32'(ng), 32'd4);
    for (int k = 0; k < 4; k++) check("rr_order", 32'(ord[k]), 32'(k % 2));
    drain();
    @(posedge Clock); #1;

    // stores
    d_txn("sb", 1'b1, 32'h13, 32'h000000AB, 2'b00, 1'b0, 32'h0, 4'b0001, 32'hABABABAB, 32'h11223344);
    d_txn("sh", 1'b1, 32'h12, 32'h00001234, 2'b01, 1'b0, 32'h0, 4'b0011, 32'h12341234, 32'h11223344);

    // loads from 0x80FF7F01
    d_txn("lb0s", 1'b0, 32'h20, 32'h0, 2'b00, 1'b0, 32'h80FF7F01, 4'b0000, 32'h0, 32'hFFFFFF80);
    d_txn("lb0u", 1'b0, 32'h20, 32'h0, 2'b00, 1'b1, 32'h80FF7F01, 4'b0000, 32'h0, 32'h00000080);
    d_txn("lh2s", 1'b0, 32'h22, 32'h0, 2'b01, 1'b0, 32'h80FF7F01, 4'b0000, 32'h0, 32'h00007F01);
    d_txn("lh0u", 1'b0, 32'h20, 32'h0, 2'b01, 1'b1, 32'h80FF7F01, 4'b0000, 32'h0, 32'h000080FF);
    d_txn("lb3s", 1'b0, 32'h23, 32'h0, 2'b00, 1'b0, 32'h80FF7F01, 4'b0000, 32'h0, 32'h00000001);
    d_txn("lb1s", 1'b0, 32'h21, 32'h0, 2'b00, 1'b0, 32'h80FF7F01, 4'b0000, 32'h0, 32'hFFFFFFFF);
    d_txn("lh0s", 1'b0, 32'h20, 32'h0, 2'b01, 1'b0, 32'h80FF7F01, 4'b0000, 32'h0, 32'hFFFF80FF);
    d_txn("sw", 1'b1, 32'h24, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 4'b1111, 32'hDEADBEEF, 32'hFFFF80FF);

    // misaligned word loses nothing for a pending fetch
    i_txn(32'h00400008, 32'h24020001);
    IReq = 1'b1; IAddr = 32'h0040000C; MemRData = 32'h03E00008;
    DReq = 1'b1; DWrite = 1'b0; DAddr = 32'h6; DSize = 2'b10;
    @(negedge Clock);
    check("mis_dready", 32'(DReady), 32'd1);
    check("mis_flag", 32'(DMisaligned), 32'd1);
    check("mis_memreq", 32'(MemReq), 32'd0);
    check("mis_iready", 32'(IReady), 32'd0);
    @(posedge Clock); #1 DReq = 1'b0;
    @(negedge Clock);
    check("mis_busy", 32'(Busy), 32'd0);
    check("mis_next_iready", 32'(IReady), 32'd1);
    check("mis_next_memreq", 32'(MemReq), 32'd1);
    check("mis_next_memaddr", 32'(MemAddr), 32'h00100003);
    exp_q.push_back('{1'b0, 32'h03E00008});
    @(posedge Clock); #1 IReq = 1'b0;
    drain();
    @(posedge Clock); #1;

    // invalid size
    DReq = 1'b1; DAddr = 32'h8; DSize = 2'b11;
    @(negedge Clock);
    check("inv_dready", 32'(DReady), 32'd1);
    check("inv_flag", 32'(DMisaligned), 32'd1);
    check("inv_memreq", 32'(MemReq), 32'd0);
    @(posedge Clock); #1 DReq = 1'b0;
    repeat (3) begin
      @(negedge Clock);
      check("inv_dvalid", 32'(DValid), 32'd0);
      check("inv_busy", 32'(Busy), 32'd0);
    end
    @(posedge Clock); #1;

    // reset during BUSY_D, then a stale response
    resp_en = 1'b0;
    DReq = 1'b1; DWrite = 1'b0; DAddr = 32'h30; DSize = 2'b10; MemRData = 32'h55AA55AA;
    @(negedge Clock);
    check("abort_dready", 32'(DReady), 32'd1);
    check("abort_memreq", 32'(MemReq), 32'd1);
    @(posedge Clock); #1 DReq = 1'b0;
    @(negedge Clock);
    check("abort_busy", 32'(Busy), 32'd1);
    #2 Reset = 1'b0;
    #1;
    check("abort_busy_rst", 32'(Busy), 32'd0);
    check("abort_drdata_rst", DRData, 32'd0);
    @(posedge Clock); #1 Reset = 1'b1; resp_en = 1'b1;
    stale_v = 1'b1;
    @(posedge Clock); #1 stale_v = 1'b0;
    repeat (2) begin
      @(negedge Clock);
      check("stale_dvalid", 32'(DValid), 32'd0);
      check("stale_busy", 32'(Busy), 32'd0);
    end
    @(posedge Clock); #1;
    i_txn(32'h00400010, 32'hAABBCCDD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
